prog_sequencer: RTL and testbench
=================================

# prog_sequencer

Batch controller in front of the basic processor core. It launches up to 2^PW programs back-to-back by pulsing the core's start input and selecting the program index. It waits for the core's done flag and records a per-program cycle count. It replaces hand-driven Start/Ack sequencing in the top-level bench and sits between the host/testbench and the core's Start/Ack ports.

## Interface
Parameters:
- PW, 2: width of program index; maximum batch of 2^PW programs
- CW, 16: cycle-counter width
- WDOG, 1023: watchdog limit in RUN cycles; used only with SEQ_WATCHDOG_EN; must be < 2^CW

Ports:
- Clk  in  1  clock, posedge
- Reset  in  1  asynchronous, active-high; returns block to IDLE
- Start  in  1  host request to run a batch; level-sampled in IDLE/DONE
- NumProgs  in  PW+1  programs in batch, 0..2^PW; sampled with Start
- CoreAck  in  1  done flag from core (its Ack)
- CoreStart  out  1  to core Start; high for exactly one cycle per program
- ProgSel  out  PW  index of program being run
- CycleCt  out  CW  RUN-cycle count of last completed program
- CtValid  out  1  one-cycle pulse when CycleCt updates
- Busy  out  1  high in LAUNCH/RUN/NEXT
- Done  out  1  batch complete; held until next accepted Start
- Timeout  out  1  sticky watchdog flag; constant 0 without SEQ_WATCHDOG_EN

## Operation
- States: IDLE, LAUNCH, RUN, NEXT, DONE.
- IDLE/DONE + Start=1:
  - latch NumProgs into Remaining
  - clear ProgSel, Done, Timeout
  - go to LAUNCH if NumProgs≠0, else DONE with Done=1 and no CoreStart
- LAUNCH: CoreStart=1, run counter cleared to 0 → RUN.
- RUN: counter increments every cycle, saturating at all-ones. CoreAck is sampled only here. On CoreAck=1, the cycle is counted, then → NEXT.
- NEXT:
  - CycleCt←counter, CtValid=1, Remaining−1
  - if Remaining was 1 → DONE with Done=1
  - else ProgSel+1 → LAUNCH
- CoreAck outside RUN is ignored, including a stale Ack during LAUNCH.
- Start while Busy is ignored; NumProgs changes mid-batch have no effect.
- ProgSel never wraps: the maximum NumProgs=2^PW ends at ProgSel=2^PW−1.
- Reset mid-batch: immediate asynchronous return to IDLE; no CtValid for the aborted program.
- Reset values: CoreStart=0, ProgSel=0, CycleCt=0, CtValid=0, Busy=0, Done=0, Timeout=0, counter=0, Remaining=0.

## Timing
- Start high at edge t → LAUNCH in cycle t+1, CoreStart high during t+1 → RUN from t+2.
- CoreAck high in the k-th RUN cycle → CycleCt=k and CtValid during the following cycle (NEXT).
- Per-program overhead: 2 cycles (LAUNCH+NEXT). The next CoreStart falls in the cycle after NEXT.
- Done rises in the cycle after the final NEXT.
- All outputs are registered except Busy, which is decoded from the state register.

## Configuration
- SEQ_WATCHDOG_EN defined: if the counter reaches WDOG in RUN without CoreAck:
  - CycleCt←WDOG, CtValid pulses, Timeout=1 (sticky until next accepted Start)
  - → DONE with Done=1, remaining programs abandoned
- CoreAck in the same cycle as the limit is reached takes priority: normal NEXT, no Timeout.
- Undefined: no watchdog logic; Timeout tied 0; RUN waits indefinitely and the counter saturates.

## Structure
- Package seq_pkg: state enum typedef (seq_state_t), default PW/CW/WDOG localparams.
- One sub-module, sat_counter (CW-bit, clear/enable, saturating), used for the run counter.

## Test plan
- NumProgs=3, CoreAck at RUN cycles 5, 1, 9 → ProgSel 0,1,2; CycleCt 5,1,9 with 3 CtValid pulses; Done 1 cycle after third NEXT; exactly 3 CoreStart pulses.
- NumProgs=0, Start → Done next cycle, no CoreStart, no CtValid.
- CoreAck held high throughout LAUNCH → ignored; CycleCt=1 since Ack is seen in first RUN cycle.
- Reset asserted mid-RUN of program 1 of 4 → all outputs 0 asynchronously; new Start afterwards restarts at ProgSel=0.
- With SEQ_WATCHDOG_EN, WDOG=20, CoreAck never → CycleCt=20, Timeout=1, Done=1 after 20 RUN cycles; second Start clears Timeout. Without the macro → still in RUN after 1000 cycles, Timeout=0.
- Start pulsed while Busy → no effect on Remaining or ProgSel.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and default parameters for the program batch sequencer.
//   seq_state_t : sequencer FSM state encoding
//   DefPw       : default program-index width
//   DefCw       : default cycle-counter width
//   DefWdog     : default watchdog limit in RUN cycles
package seq_pkg;

  localparam int unsigned DefPw   = 2;
  localparam int unsigned DefCw   = 16;
  localparam int unsigned DefWdog = 1023;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StRun,
    StNext,
    StDone
  } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Ports:
//   clk, rst   : clock (posedge) and asynchronous active-high reset
//   clr        : synchronous clear to zero, takes priority over en
//   en         : increment by one, holding at all-ones
//   count      : registered count value
//   count_next : value count takes at the next edge
module sat_counter #(
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_next
);

  logic [CW-1:0] count_q;

  always_comb begin
    count_next = count_q;
    if (clr) begin
      count_next = '0;
    end else if (en && (count_q != '1)) begin
      count_next = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_next;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/prog_sequencer.sv
// Batch controller that launches up to 2^PW programs on the core back-to-back,
// pulsing CoreStart per program and recording each program's RUN-cycle count.
// Optional feature macro: SEQ_WATCHDOG_EN (RUN watchdog of WDOG cycles).
// Ports:
//   Clk, Reset : clock (posedge), asynchronous active-high reset to IDLE
//   Start      : host batch request, sampled in IDLE/DONE
//   NumProgs   : programs in batch (0..2^PW), sampled with Start
//   CoreAck    : core done flag, sampled only in RUN
//   CoreStart  : one-cycle start pulse to core per program
//   ProgSel    : index of program being run
//   CycleCt    : RUN-cycle count of last completed program
//   CtValid    : one-cycle pulse when CycleCt updates
//   Busy       : high in LAUNCH/RUN/NEXT (decoded from state)
//   Done       : batch complete, held until next accepted Start
//   Timeout    : sticky watchdog flag (0 without SEQ_WATCHDOG_EN)
module prog_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned PW   = DefPw,
  parameter int unsigned CW   = DefCw,
  parameter int unsigned WDOG = DefWdog
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [PW:0]   NumProgs,
  input  logic          CoreAck,
  output logic          CoreStart,
  output logic [PW-1:0] ProgSel,
  output logic [CW-1:0] CycleCt,
  output logic          CtValid,
  output logic          Busy,
  output logic          Done,
  output logic          Timeout
);

  seq_state_t    state_q, state_d;
  logic [PW:0]   remaining_q, remaining_d;
  logic [PW-1:0] prog_sel_q, prog_sel_d;
  logic [CW-1:0] cycle_ct_q, cycle_ct_d;
  logic          ct_valid_q, ct_valid_d;
  logic          done_q, done_d;
  logic          core_start_q, core_start_d;
  logic          cnt_clr, cnt_en;
  logic [CW-1:0] cnt, cnt_next;
`ifdef SEQ_WATCHDOG_EN
  logic          timeout_q, timeout_d;
  localparam logic [CW-1:0] WdogLim = CW'(WDOG);
`endif

  sat_counter #(
    .CW(CW)
  ) u_run_cnt (
    .clk       (Clk),
    .rst       (Reset),
    .clr       (cnt_clr),
    .en        (cnt_en),
    .count     (cnt),
    .count_next(cnt_next)
  );

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    prog_sel_d   = prog_sel_q;
    cycle_ct_d   = cycle_ct_q;
    ct_valid_d   = 1'b0;
    done_d       = done_q;
    core_start_d = 1'b0;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
`ifdef SEQ_WATCHDOG_EN
    timeout_d    = timeout_q;
`endif

    unique case (state_q)
      StIdle, StDone: begin
        if (Start) begin
          remaining_d = NumProgs;
          prog_sel_d  = '0;
          done_d      = 1'b0;
`ifdef SEQ_WATCHDOG_EN
          timeout_d   = 1'b0;
`endif
          if (NumProgs != '0) begin
            state_d      = StLaunch;
            core_start_d = 1'b1;
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      StLaunch: begin
        cnt_clr = 1'b1;
        state_d = StRun;
      end
      StRun: begin
        cnt_en = 1'b1;
        // Capture the count including this cycle so CycleCt is valid during NEXT.
        if (CoreAck) begin
          cycle_ct_d = cnt_next;
          ct_valid_d = 1'b1;
          state_d    = StNext;
        end
`ifdef SEQ_WATCHDOG_EN
        else if (cnt_next == WdogLim) begin
          cycle_ct_d = WdogLim;
          ct_valid_d = 1'b1;
          timeout_d  = 1'b1;
          done_d     = 1'b1;
          state_d    = StDone;
        end
`endif
      end
      StNext: begin
        remaining_d = remaining_q - 1'b1;
        if (remaining_q == (PW+1)'(1)) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          prog_sel_d   = prog_sel_q + 1'b1;
          state_d      = StLaunch;
          core_start_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= StIdle;
      remaining_q  <= '0;
      prog_sel_q   <= '0;
      cycle_ct_q   <= '0;
      ct_valid_q   <= 1'b0;
      done_q       <= 1'b0;
      core_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      prog_sel_q   <= prog_sel_d;
      cycle_ct_q   <= cycle_ct_d;
      ct_valid_q   <= ct_valid_d;
      done_q       <= done_d;
      core_start_q <= core_start_d;
    end
  end

`ifdef SEQ_WATCHDOG_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end
  assign Timeout = timeout_q;
`else
  assign Timeout = 1'b0;
`endif

  assign CoreStart = core_start_q;
  assign ProgSel   = prog_sel_q;
  assign CycleCt   = cycle_ct_q;
  assign CtValid   = ct_valid_q;
  assign Done      = done_q;
  assign Busy      = (state_q == StLaunch) || (state_q == StRun) || (state_q == StNext);

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed self-checking bench for prog_sequencer. Inputs are driven and
// outputs sampled at the falling clock edge; CoreStart/CtValid pulses are
// tallied at every sample point.
module tb_prog_sequencer;

  localparam int unsigned PW = 2;
  localparam int unsigned CW = 16;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Start;
  logic [PW:0]   NumProgs;
  logic          CoreAck;
  logic          CoreStart;
  logic [PW-1:0] ProgSel;
  logic [CW-1:0] CycleCt;
  logic          CtValid;
  logic          Busy;
  logic          Done;
  logic          Timeout;

  int checks = 0;
  int errors = 0;
  int cs_cnt = 0;
  int cv_cnt = 0;
  int cs_base;
  int cv_base;

  prog_sequencer #(
    .PW  (PW),
    .CW  (CW),
    .WDOG(20)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .NumProgs (NumProgs),
    .CoreAck  (CoreAck),
    .CoreStart(CoreStart),
    .ProgSel  (ProgSel),
    .CycleCt  (CycleCt),
    .CtValid  (CtValid),
    .Busy     (Busy),
    .Done     (Done),
    .Timeout  (Timeout)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(negedge Clk);
    if (CoreStart === 1'b1) cs_cnt++;
    if (CtValid === 1'b1) cv_cnt++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Entered at the sample point of a LAUNCH cycle; acks in RUN cycle k.
  task automatic run_prog(input int k, input int sel, input bit last);
    chk("launch_corestart", 32'(CoreStart), 1);
    chk("launch_progsel", 32'(ProgSel), sel);
    chk("launch_busy", 32'(Busy), 1);
    tick();
    chk("run_corestart", 32'(CoreStart), 0);
    repeat (k - 1) tick();
    CoreAck = 1'b1;
    tick();
    CoreAck = 1'b0;
    chk("next_cyclect", 32'(CycleCt), k);
    chk("next_ctvalid", 32'(CtValid), 1);
    chk("next_done", 32'(Done), 0);
    tick();
    chk("after_next_ctvalid", 32'(CtValid), 0);
    if (last) begin
      chk("batch_done", 32'(Done), 1);
      chk("batch_busy", 32'(Busy), 0);
      chk("batch_progsel", 32'(ProgSel), sel);
    end
  endtask

  initial begin
    Reset    = 1'b1;
    Start    = 1'b0;
    NumProgs = '0;
    CoreAck  = 1'b0;
    tick();
    chk("rst_corestart", 32'(CoreStart), 0);
    chk("rst_progsel", 32'(ProgSel), 0);
    chk("rst_cyclect", 32'(CycleCt), 0);
    chk("rst_ctvalid", 32'(CtValid), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_timeout", 32'(Timeout), 0);
    Reset = 1'b0;
    tick();

    // Empty batch: straight to DONE, no core activity.
    cs_base = cs_cnt; cv_base = cv_cnt;
    Start = 1'b1; NumProgs = 0;
    tick();
    Start = 1'b0;
    chk("empty_done", 32'(Done), 1);
    chk("empty_busy", 32'(Busy), 0);
    tick();
    chk("empty_done_held", 32'(Done), 1);
    chk("empty_no_corestart", 32'(cs_cnt - cs_base), 0);
    chk("empty_no_ctvalid", 32'(cv_cnt - cv_base), 0);

    // Three programs acking in RUN cycles 5, 1, 9.
    cs_base = cs_cnt; cv_base = cv_cnt;
    Start = 1'b1; NumProgs = 3;
    tick();
    Start = 1'b0;
    chk("b3_done_cleared", 32'(Done), 0);
    run_prog(5, 0, 1'b0);
    run_prog(1, 1, 1'b0);
    run_prog(9, 2, 1'b1);
    chk("b3_corestarts", 32'(cs_cnt - cs_base), 3);
    chk("b3_ctvalids", 32'(cv_cnt - cv_base), 3);

    // Ack held through DONE and LAUNCH: only seen in the first RUN cycle.
    Start = 1'b1; NumProgs = 1; CoreAck = 1'b1;
    tick();
    Start = 1'b0;
    chk("stale_launch_corestart", 32'(CoreStart), 1);
    tick();
    chk("stale_run_ctvalid", 32'(CtValid), 0);
    tick();
    CoreAck = 1'b0;
    chk("stale_cyclect", 32'(CycleCt), 1);
    chk("stale_ctvalid", 32'(CtValid), 1);
    tick();
    chk("stale_done", 32'(Done), 1);

    // Start held and NumProgs changed mid-batch: batch stays at 2 programs.
    cs_base = cs_cnt;
    Start = 1'b1; NumProgs = 2;
    tick();
    NumProgs = 4;
    run_prog(3, 0, 1'b0);
    Start = 1'b0;
    run_prog(2, 1, 1'b1);
    chk("busy_start_corestarts", 32'(cs_cnt - cs_base), 2);

    // Asynchronous reset during RUN of program 1 of 4.
    Start = 1'b1; NumProgs = 4;
    tick();
    Start = 1'b0;
    run_prog(2, 0, 1'b0);
    tick();
    tick();
    cv_base = cv_cnt;
    Reset = 1'b1;
    #1;
    chk("arst_progsel", 32'(ProgSel), 0);
    chk("arst_cyclect", 32'(CycleCt), 0);
    chk("arst_ctvalid", 32'(CtValid), 0);
    chk("arst_busy", 32'(Busy), 0);
    chk("arst_done", 32'(Done), 0);
    chk("arst_corestart", 32'(CoreStart), 0);
    tick();
    Reset = 1'b0;
    tick();
    chk("arst_no_ctvalid", 32'(cv_cnt - cv_base), 0);
    Start = 1'b1; NumProgs = 1;
    tick();
    Start = 1'b0;
    run_prog(3, 0, 1'b1);

`ifdef SEQ_WATCHDOG_EN
    // No ack: watchdog fires at the end of RUN cycle 20.
    Start = 1'b1; NumProgs = 2;
    tick();
    Start = 1'b0;
    tick();
    repeat (19) tick();
    chk("wd_pre_busy", 32'(Busy), 1);
    chk("wd_pre_timeout", 32'(Timeout), 0);
    tick();
    chk("wd_cyclect", 32'(CycleCt), 20);
    chk("wd_ctvalid", 32'(CtValid), 1);
    chk("wd_timeout", 32'(Timeout), 1);
    chk("wd_done", 32'(Done), 1);
    chk("wd_progsel", 32'(ProgSel), 0);
    tick();
    chk("wd_timeout_sticky", 32'(Timeout), 1);
    Start = 1'b1; NumProgs = 1;
    tick();
    Start = 1'b0;
    chk("wd_timeout_cleared", 32'(Timeout), 0);
    // Ack on the limit cycle wins over the watchdog.
    run_prog(20, 0, 1'b1);
    chk("wd_ack_priority", 32'(Timeout), 0);
`else
    // No watchdog: RUN waits indefinitely.
    cv_base = cv_cnt;
    Start = 1'b1; NumProgs = 1;
    tick();
    Start = 1'b0;
    tick();
    repeat (1000) tick();
    chk("nowd_busy", 32'(Busy), 1);
    chk("nowd_timeout", 32'(Timeout), 0);
    chk("nowd_done", 32'(Done), 0);
    chk("nowd_no_ctvalid", 32'(cv_cnt - cv_base), 0);
    CoreAck = 1'b1;
    tick();
    CoreAck = 1'b0;
    chk("nowd_cyclect", 32'(CycleCt), 1001);
    tick();
    chk("nowd_done_final", 32'(Done), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
